// File: rtl/i2f_32_seq.sv
// i2f_32_seq: sequential int32 -> IEEE-754 single converter, one normalising shift per cycle.
// Define I2F_32_SEQ_RNE_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module i2f_32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] d,
    output logic        p_lost,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;
    state_t      state_q;
    logic        sign_q;
    logic        zero_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [31:0] d_q;
    logic        p_lost_q;
    logic [31:0] a_mag;
    logic        round_up;
    logic [23:0] frac_r;
    logic [7:0]  exp_r;
    assign a_mag = a[31] ? -a : a;
`ifdef I2F_32_SEQ_RNE_EN
    assign round_up = mag_q[7] && (|mag_q[6:0] || mag_q[8]);
`else
    assign round_up = 1'b0;
`endif
    // A carry out of the fraction bumps the exponent; exp_q <= 158 keeps this finite.
    assign frac_r = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    assign exp_r = exp_q + {7'd0, frac_r[23]};
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign d = d_q;
    assign p_lost = p_lost_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            d_q      <= '0;
            p_lost_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sign_q  <= a[31];
                    mag_q   <= a_mag;
                    exp_q   <= 8'd158;
                    zero_q  <= a_mag == 32'd0;
                    state_q <= a_mag == 32'd0 ? PACK : NORM;
                end
                NORM: if (mag_q[31]) state_q <= PACK;
                    else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                PACK: begin
                    d_q      <= zero_q ? 32'd0 : {sign_q, exp_r, frac_r[22:0]};
                    p_lost_q <= !zero_q && |mag_q[7:0];
                    state_q  <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2f_32_seq.sv
// tb_i2f_32_seq: directed and randomized checks of i2f_32_seq against an arithmetic reference model.
module tb_i2f_32_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] d;
    logic        p_lost;
    logic        out_valid;
    logic        out_ready = 1'b0;
    int checks = 0;
    int errors = 0;
    i2f_32_seq dut (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .p_lost(p_lost), .out_valid(out_valid), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    // Reference: exact binary value of a, rounded at 24 significant bits.
    task automatic model(input logic [31:0] op, output logic [31:0] ed, output logic ep, output int elat);
        logic s;
        longint unsigned m, fr, rem, half;
        int p, e, sh;
        s = op[31];
        m = 64'(op);
        if (s) m = 64'h1_0000_0000 - m;
        if (m == 0) begin
            ed = '0; ep = 1'b0; elat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 33; i++) if (m[i]) p = i;
        e = 127 + p;
        if (p <= 23) begin
            fr = m << (23 - p);
            ep = 1'b0;
        end else begin
            sh = p - 23;
            fr = m >> sh;
            rem = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            ep = rem != 0;
`ifdef I2F_32_SEQ_RNE_EN
            if (rem > half || (rem == half && fr[0])) fr++;
`endif
            if (fr == (64'd1 << 24)) begin
                fr = fr >> 1;
                e++;
            end
        end
        ed = {s, 8'(e), fr[22:0]};
        elat = 33 - p;
    endtask
    task automatic run_op(input logic [31:0] op, input int hold, output logic [31:0] gd, output logic gp, output int lat);
        logic [31:0] ed, held;
        logic ep;
        int elat;
        model(op, ed, ep, elat);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        gd = d;
        gp = p_lost;
        check("out_valid", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(elat));
        check("d", d, ed);
        check("p_lost", 32'(p_lost), 32'(ep));
        held = d;
        for (int i = 0; i < hold; i++) begin
            a = $urandom;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_d", d, held);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_d", d, held);
    endtask
    typedef struct { logic [31:0] op; logic [31:0] rne; logic [31:0] trn; logic p; int lat; } vec_t;
    vec_t vecs[7] = '{
        '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 33},
        '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 33},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1},
        '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 1'b0, 2},
        '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 1'b1, 3},
        '{32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000, 1'b1, 9},
        '{32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001, 1'b1, 9}
    };
    initial begin
        logic [31:0] gd, op;
        logic gp;
        int lat;
        #1;
        check("rst_d", d, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p_lost", 32'(p_lost), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, (i == 4) ? 5 : 0, gd, gp, lat);
`ifdef I2F_32_SEQ_RNE_EN
            check("dir_d", gd, vecs[i].rne);
`else
            check("dir_d", gd, vecs[i].trn);
`endif
            check("dir_p", 32'(gp), 32'(vecs[i].p));
            check("dir_lat", 32'(lat), 32'(vecs[i].lat));
        end
        run_op(32'h0000_0100, 0, gd, gp, lat);
        @(negedge clk);
        a = 32'h0000_0100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_d", d, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 0, gd, gp, lat);
        check("after_abort_d", gd, 32'h4000_0000);
        for (int n = 0; n < 200; n++) begin
            op = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) op = -op;
            if (n % 37 == 0) op = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
            run_op(op, $urandom_range(0, 3), gd, gp, lat);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
